// File: rtl/timer_pkg.sv
// Shared types and constants for the interval sequencer and its down-counter pairing.
package timer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } seq_state_t;

  typedef enum logic {
    MODE_ONESHOT,
    MODE_PERIODIC
  } timer_mode_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/interval_sequencer.sv
// Control stage for an external down counter: loads the period, watches the zero flag,
// re-arms or halts, and keeps a sticky interrupt plus saturating expiry statistics.
module interval_sequencer
  import timer_pkg::*;
#(
  parameter int WIDTH  = CNT_W,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [WIDTH-1:0]  period_in,
  input  logic              period_wr,
  input  logic              periodic,
  input  logic              start,
  input  logic              stop,
  input  logic              halve_req,
  input  logic              irq_ack,
  input  logic              clr_stats,
  input  logic              cnt_zero,
  output logic              load,
  output logic [WIDTH-1:0]  preload_count,
  output logic              divide_by_2,
  output logic              busy,
  output logic              irq,
  output logic              overrun,
  output logic [STAT_W-1:0] expire_cnt
);

  seq_state_t       state_q, state_d;
  timer_mode_t      mode_q, mode_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             expire;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    expire   = 1'b0;
    period_d = period_wr ? period_in : period_q;

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        mode_d  = periodic ? MODE_PERIODIC : MODE_ONESHOT;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // cnt_zero is only trusted here; in LOAD it still reflects the previous count
        if (cnt_zero) begin
          expire  = 1'b1;
          state_d = (mode_q == MODE_PERIODIC) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop) begin
      state_d = ST_IDLE;
      expire  = 1'b0;
    end

    irq_d = expire ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    ovr_d = (expire && irq_q) ? 1'b1 : (irq_ack ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ONESHOT;
      period_q <= '1;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_expire_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc   (expire),
    .clr   (clr_stats),
    .count (expire_cnt)
  );

  assign load          = (state_q == ST_LOAD);
  assign busy          = (state_q != ST_IDLE);
  assign preload_count = period_q;
  assign irq           = irq_q;
  assign overrun       = ovr_q;
  assign divide_by_2   = (state_q == ST_RUN) && halve_req && !cnt_zero;

endmodule

// File: tb/tb_interval_sequencer.sv
// Bench for interval_sequencer paired with a behavioural 8-bit down counter.
module tb_interval_sequencer;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic [W-1:0]  period_in;
  logic          period_wr, periodic, start, stop, halve_req, irq_ack, clr_stats, cnt_zero;
  logic          load, divide_by_2, busy, irq, overrun;
  logic [W-1:0]  preload_count;
  logic [SW-1:0] expire_cnt;
  logic [W-1:0]  tb_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  interval_sequencer #(.WIDTH(W), .STAT_W(SW)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .period_in     (period_in),
    .period_wr     (period_wr),
    .periodic      (periodic),
    .start         (start),
    .stop          (stop),
    .halve_req     (halve_req),
    .irq_ack       (irq_ack),
    .clr_stats     (clr_stats),
    .cnt_zero      (cnt_zero),
    .load          (load),
    .preload_count (preload_count),
    .divide_by_2   (divide_by_2),
    .busy          (busy),
    .irq           (irq),
    .overrun       (overrun),
    .expire_cnt    (expire_cnt)
  );

  // Down counter the sequencer drives
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                tb_cnt <= '0;
    else if (load)            tb_cnt <= preload_count;
    else if (divide_by_2)     tb_cnt <= tb_cnt >> 1;
    else if (tb_cnt != '0)    tb_cnt <= tb_cnt - 1'b1;
  end
  assign cnt_zero = (tb_cnt == '0);

  // Reference model: "armed" flag, "this cycle is the load cycle" flag, and the count value
  bit m_busy, m_loading, m_periodic, m_irq, m_ovr;
  int m_period, m_cnt, m_exp;

  int  loads[$];
  int  exps[$];
  int  irq_rise;
  bit  prev_irq;
  bit  s_load, s_busy, s_irq;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_loading = 0; m_periodic = 0; m_irq = 0; m_ovr = 0;
    m_period = 255; m_cnt = 0; m_exp = 0;
  endtask

  task automatic clear_strobes();
    period_wr = 0; start = 0; stop = 0; halve_req = 0; irq_ack = 0; clr_stats = 0;
  endtask

  task automatic step();
    bit expiry, div;
    int n_cnt;
    @(negedge clk);
    div = m_busy && !m_loading && halve_req && (m_cnt != 0);
    check("load", int'(load), int'(m_loading));
    check("busy", int'(busy), int'(m_busy));
    check("preload", int'(preload_count), m_period);
    check("irq", int'(irq), int'(m_irq));
    check("overrun", int'(overrun), int'(m_ovr));
    check("expire_cnt", int'(expire_cnt), m_exp);
    check("divide_by_2", int'(divide_by_2), int'(div));
    check("count", int'(tb_cnt), m_cnt);
    s_load = load; s_busy = busy; s_irq = irq;
    if (load) begin
      loads.push_back(cyc);
      exps.push_back(int'(expire_cnt));
    end
    if (irq && !prev_irq) irq_rise = cyc;
    prev_irq = irq;

    expiry = m_busy && !m_loading && (m_cnt == 0) && !stop;
    if (m_loading)    n_cnt = m_period;
    else if (div)     n_cnt = m_cnt / 2;
    else if (m_cnt>0) n_cnt = m_cnt - 1;
    else              n_cnt = 0;
    m_cnt = n_cnt;

    if (stop) begin
      m_busy = 0; m_loading = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_loading = 1; end
    end else if (m_loading) begin
      m_loading = 0; m_periodic = periodic;
    end else if (expiry) begin
      if (m_periodic) m_loading = 1;
      else            m_busy = 0;
    end

    m_ovr = (expiry && m_irq) ? 1'b1 : (irq_ack ? 1'b0 : m_ovr);
    m_irq = expiry ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
    if (clr_stats)                      m_exp = 0;
    else if (expiry && m_exp < STAT_MAX) m_exp = m_exp + 1;
    if (period_wr) m_period = int'(period_in);

    @(posedge clk);
    #1;
    cyc++;
    clear_strobes();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_load(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = s_load;
    end
    if (!got) check("wait_load_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int v, input int budget);
    int k = 0;
    while (int'(tb_cnt) != v && k < budget) begin
      step();
      k++;
    end
    if (int'(tb_cnt) != v) check("wait_cnt_timeout", int'(tb_cnt), v);
  endtask

  task automatic scenario_start(input int p, input bit per);
    irq_ack = 1; clr_stats = 1; period_in = W'(p); period_wr = 1;
    step();
    loads.delete(); exps.delete(); irq_rise = -1;
    periodic = per; start = 1;
    step();
  endtask

  typedef struct {
    bit       pwr;
    bit [7:0] pin;
    bit       st;
    bit       ack;
    bit       e_load;
    bit       e_busy;
    bit       e_irq;
  } vec_t;
  vec_t tbl[12];

  initial begin
    // one-shot, period 3: one load, expiry 5 cycles after it, then idle with irq held until ack
    tbl[0]  = '{1, 8'd3, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 8'd0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 8'd0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 8'd0, 0, 0, 0, 1, 0};
    tbl[4]  = '{0, 8'd0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 8'd0, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 8'd0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 8'd0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 8'd0, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, 8'd0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 8'd0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 8'd0, 0, 0, 0, 0, 0};

    nrst = 0; period_in = '0; periodic = 0; prev_irq = 0; irq_rise = -1;
    clear_strobes();
    model_reset();
    @(negedge clk);
    check("rst_load", int'(load), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_irq", int'(irq), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_expire", int'(expire_cnt), 0);
    check("rst_preload", int'(preload_count), 255);
    check("rst_div", int'(divide_by_2), 0);
    @(posedge clk); #1;
    nrst = 1;

    // table: one-shot sequence
    periodic = 0;
    for (int i = 0; i < 12; i++) begin
      period_wr = tbl[i].pwr; period_in = tbl[i].pin; start = tbl[i].st; irq_ack = tbl[i].ack;
      step();
      check($sformatf("tbl%0d_load", i), int'(s_load), int'(tbl[i].e_load));
      check($sformatf("tbl%0d_busy", i), int'(s_busy), int'(tbl[i].e_busy));
      check($sformatf("tbl%0d_irq", i), int'(s_irq), int'(tbl[i].e_irq));
    end

    // periodic, period 5: 7-cycle cadence, irq one cycle after first zero, count of 3
    scenario_start(5, 1);
    run(23);
    check("s1_load_count", loads.size(), 4);
    if (loads.size() >= 4) begin
      check("s1_interval_a", loads[1] - loads[0], 7);
      check("s1_interval_b", loads[2] - loads[1], 7);
      check("s1_irq_rise", irq_rise, loads[0] + 7);
      check("s1_expire3", exps[3], 3);
    end
    stop = 1; step(); step();
    check("s1_stopped", int'(busy), 0);

    // periodic, period 0: 2-cycle cadence, overrun, ack coinciding with expiry
    scenario_start(0, 1);
    run(2);
    check("s3_irq_first", int'(irq), 1);
    check("s3_ovr_first", int'(overrun), 0);
    run(2);
    check("s3_ovr_second", int'(overrun), 1);
    if (loads.size() >= 2) check("s3_interval", loads[1] - loads[0], 2);
    else                   check("s3_load_count", loads.size(), 2);
    if (load) step();
    irq_ack = 1; step();
    check("s3_ack_exp_irq", int'(irq), 1);
    check("s3_ack_exp_ovr", int'(overrun), 1);
    irq_ack = 1; step();
    check("s3_ack_irq", int'(irq), 0);
    check("s3_ack_ovr", int'(overrun), 0);
    stop = 1; step();

    // period 200: ignored restart, halve at 100, stop at 20
    scenario_start(200, 1);
    wait_cnt(150, 300);
    start = 1; step();
    check("s4_restart_load", int'(load), 0);
    wait_cnt(100, 100);
    halve_req = 1; step();
    check("s4_halved", int'(tb_cnt), 50);
    wait_cnt(20, 100);
    stop = 1; step();
    check("s4_stop_busy", int'(busy), 0);
    step();
    check("s4_stop_irq", int'(irq), 0);
    check("s4_stop_stats", int'(expire_cnt), 0);

    // period rewrite mid-run affects only the next load
    scenario_start(4, 1);
    wait_load(5);
    run(2);
    period_in = 8'd9; period_wr = 1; step();
    run(20);
    check("s5_load_count", loads.size(), 3);
    if (loads.size() >= 3) begin
      check("s5_interval_old", loads[1] - loads[0], 6);
      check("s5_interval_new", loads[2] - loads[1], 11);
    end
    stop = 1; step();

    // saturation of the expiry counter, then clear
    scenario_start(0, 1);
    run(40);
    check("s5_saturated", int'(expire_cnt), STAT_MAX);
    clr_stats = 1; step();
    check("s5_cleared", int'(expire_cnt), 0);
    run(3);

    // asynchronous reset mid-run
    halve_req = 1;
    #3 nrst = 0;
    #1;
    check("s6_load", int'(load), 0);
    check("s6_busy", int'(busy), 0);
    check("s6_irq", int'(irq), 0);
    check("s6_overrun", int'(overrun), 0);
    check("s6_expire", int'(expire_cnt), 0);
    check("s6_preload", int'(preload_count), 255);
    check("s6_div", int'(divide_by_2), 0);
    halve_req = 0;
    model_reset();
    @(posedge clk); #1;
    nrst = 1;
    step();
    check("s6_idle", int'(s_busy), 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      period_in = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      period_wr = ($urandom_range(0, 9) == 0);
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      halve_req = ($urandom_range(0, 9) == 0);
      irq_ack   = ($urandom_range(0, 6) == 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      periodic  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
